// File: rtl/weights_loader.sv
// weights_loader
//   Reads one kernel out of a synchronous weights ROM (1-cycle read latency)
//   into a parallel register bank, presented as one flat bus to the conv MAC
//   array. One load per accepted start pulse; the kernel is held until it is
//   cleared or reloaded.
//
// Optional feature macro: WLOAD_CHECKSUM_EN
//   defined   -> kernel_sum port plus a running signed sum of captured weights
//   undefined -> no kernel_sum port, no accumulator
//
// Ports
//   clk          in   1                      rising-edge clock
//   rst          in   1                      asynchronous active-high reset
//   load_start   in   1                      request to (re)load the kernel
//   kernel_clr   in   1                      drop kernel_valid, zero the bank
//   rom_r_en     out  1                      ROM read enable
//   rom_raddr    out  ADDR_WIDTH             ROM read address
//   rom_dout     in   PARA_WIDTH             ROM data, valid 1 cycle after rom_r_en
//   busy         out  1                      load in progress
//   load_done    out  1                      1-cycle pulse when the bank is complete
//   kernel_valid out  1                      kernel_bus holds a complete kernel
//   kernel_bus   out  KERNEL_SIZE*PARA_WIDTH weight i at [i*PARA_WIDTH +: PARA_WIDTH]
//   kernel_sum   out  PARA_WIDTH+ADDR_WIDTH  signed sum of weights (checksum build only)

`ifndef CNN_PARA_WIDTH
`define CNN_PARA_WIDTH 8
`endif
`ifndef CNN_KERNEL_SIZE
`define CNN_KERNEL_SIZE 25
`endif

module weights_loader #(
  parameter int unsigned PARA_WIDTH  = `CNN_PARA_WIDTH,
  parameter int unsigned KERNEL_SIZE = `CNN_KERNEL_SIZE,
  parameter int unsigned ADDR_WIDTH  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              kernel_clr,
  output logic                              rom_r_en,
  output logic [ADDR_WIDTH-1:0]             rom_raddr,
  input  logic [PARA_WIDTH-1:0]             rom_dout,
  output logic                              busy,
  output logic                              load_done,
  output logic                              kernel_valid,
  output logic [KERNEL_SIZE*PARA_WIDTH-1:0] kernel_bus
`ifdef WLOAD_CHECKSUM_EN
  ,
  output logic [PARA_WIDTH+ADDR_WIDTH-1:0]  kernel_sum
`endif
);

  localparam int unsigned SUM_WIDTH = PARA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_rom_r_en;
  logic [ADDR_WIDTH-1:0]   r_rom_raddr;
  logic                    r_cap_en;
  logic [ADDR_WIDTH-1:0]   r_cap_addr;
  logic                    r_busy;
  logic                    r_load_done;
  logic                    r_kernel_valid;
  logic [PARA_WIDTH-1:0]   r_bank [KERNEL_SIZE];
`ifdef WLOAD_CHECKSUM_EN
  logic [SUM_WIDTH-1:0]    r_sum;
`endif

  // A clear in the same cycle frees the loader, so the start is taken even
  // when a load was in flight.
  logic w_start_ok;
  assign w_start_ok = load_start && (!r_busy || kernel_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rom_r_en     <= 1'b0;
      r_rom_raddr    <= '0;
      r_cap_en       <= 1'b0;
      r_cap_addr     <= '0;
      r_busy         <= 1'b0;
      r_load_done    <= 1'b0;
      r_kernel_valid <= 1'b0;
      for (int unsigned i = 0; i < KERNEL_SIZE; i++) r_bank[i] <= '0;
`ifdef WLOAD_CHECKSUM_EN
      r_sum          <= '0;
`endif
    end else begin
      r_load_done <= 1'b0;

      // Delayed copy of the read request qualifies rom_dout one cycle later.
      r_cap_en   <= r_rom_r_en;
      r_cap_addr <= r_rom_raddr;
      if (r_cap_en) begin
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
          if (r_cap_addr == ADDR_WIDTH'(i)) r_bank[i] <= rom_dout;
        end
`ifdef WLOAD_CHECKSUM_EN
        r_sum <= r_sum + SUM_WIDTH'(signed'(rom_dout));
`endif
      end

      case (r_state)
        S_READ: begin
          if (r_rom_raddr == LAST_ADDR) begin
            r_state     <= S_DRAIN;
            r_rom_r_en  <= 1'b0;
            r_rom_raddr <= '0;
          end else begin
            r_rom_raddr <= r_rom_raddr + 1'b1;
          end
        end
        // Last weight lands in the bank at the end of this cycle.
        S_DRAIN: begin
          r_state        <= S_DONE;
          r_load_done    <= 1'b1;
          r_kernel_valid <= 1'b1;
          r_busy         <= 1'b0;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Clear overrides the sequencing above; start (below) overrides clear.
      if (kernel_clr) begin
        r_state        <= S_IDLE;
        r_rom_r_en     <= 1'b0;
        r_rom_raddr    <= '0;
        r_cap_en       <= 1'b0;
        r_busy         <= 1'b0;
        r_load_done    <= 1'b0;
        r_kernel_valid <= 1'b0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) r_bank[i] <= '0;
`ifdef WLOAD_CHECKSUM_EN
        r_sum          <= '0;
`endif
      end

      if (w_start_ok) begin
        r_state        <= S_READ;
        r_rom_r_en     <= 1'b1;
        r_rom_raddr    <= '0;
        r_busy         <= 1'b1;
        r_load_done    <= 1'b0;
        r_kernel_valid <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
        r_sum          <= '0;
`endif
      end
    end
  end

  assign rom_r_en     = r_rom_r_en;
  assign rom_raddr    = r_rom_raddr;
  assign busy         = r_busy;
  assign load_done    = r_load_done;
  assign kernel_valid = r_kernel_valid;
`ifdef WLOAD_CHECKSUM_EN
  assign kernel_sum   = r_sum;
`endif

  always_comb begin
    kernel_bus = '0;
    for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
      kernel_bus[i*PARA_WIDTH +: PARA_WIDTH] = r_bank[i];
    end
  end

endmodule

// File: tb/tb_weights_loader.sv
module tb_weights_loader;

  localparam int W  = 8;
  localparam int KS = 25;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              kernel_clr;
  logic              rom_r_en;
  logic [AW-1:0]     rom_raddr;
  logic [W-1:0]      rom_dout = '0;
  logic              busy;
  logic              load_done;
  logic              kernel_valid;
  logic [KS*W-1:0]   kernel_bus;
`ifdef WLOAD_CHECKSUM_EN
  logic [W+AW-1:0]   kernel_sum;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] rom [32];

  weights_loader #(
    .PARA_WIDTH (W),
    .KERNEL_SIZE(KS),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .kernel_clr  (kernel_clr),
    .rom_r_en    (rom_r_en),
    .rom_raddr   (rom_raddr),
    .rom_dout    (rom_dout),
    .busy        (busy),
    .load_done   (load_done),
    .kernel_valid(kernel_valid),
    .kernel_bus  (kernel_bus)
`ifdef WLOAD_CHECKSUM_EN
    ,
    .kernel_sum  (kernel_sum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle latency, zero output when not enabled.
  always @(posedge clk) rom_dout <= rom_r_en ? rom[rom_raddr] : '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 0: weight k = k+1, 1: all 0xFF, 2: random, 3: alternating 0x80/0x7F.
  // Unused addresses hold a marker that must never reach the bank.
  task automatic set_image(input int img);
    for (int k = 0; k < 32; k++) begin
      if (k >= KS) rom[k] = 8'hEE;
      else case (img)
        0:       rom[k] = W'(k + 1);
        1:       rom[k] = 8'hFF;
        2:       rom[k] = W'($urandom);
        default: rom[k] = (k % 2 == 1) ? 8'h80 : 8'h7F;
      endcase
    end
  endtask

  // One load request; clr_at / restart_at are cycle numbers after the start
  // edge (0 = unused). Expectations: done cycle (0 = none) and read count.
  task automatic run_load(input string nm, input int clr_at, input int restart_at,
                          input bit start_clr, input int exp_done, input int exp_reads);
    logic [KS*W-1:0] exp_bus;
    int  exp_sum;
    int  reads, done_cyc, done_pulses, endc;
    bit  addr_ok, valid_low, busy_ok, early_zero;
    exp_sum = 0;
    for (int k = 0; k < KS; k++) begin
      exp_bus[k*W +: W] = rom[k];
      exp_sum += int'($signed(rom[k]));
    end
    reads = 0; done_cyc = 0; done_pulses = 0;
    addr_ok = 1'b1; valid_low = 1'b1; busy_ok = 1'b1; early_zero = 1'b1;
    endc = (exp_done != 0) ? exp_done : clr_at + 1;

    @(posedge clk); #1;
    load_start = 1'b1;
    kernel_clr = start_clr;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      load_start = (n == restart_at);
      kernel_clr = (n == clr_at);
      @(negedge clk);
      if (rom_r_en) begin
        if (rom_raddr !== AW'(reads)) addr_ok = 1'b0;
        reads++;
      end
      if (load_done) begin
        done_pulses++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (n < endc && kernel_valid) valid_low = 1'b0;
      if (busy !== (n < endc)) busy_ok = 1'b0;
      if (start_clr && n <= 2 && kernel_bus != '0) early_zero = 1'b0;
      @(posedge clk); #1;
    end
    load_start = 1'b0;
    kernel_clr = 1'b0;

    chk({nm, ".reads"},      reads,       exp_reads);
    chk({nm, ".addr_seq"},   addr_ok,     1'b1);
    chk({nm, ".done_cycle"}, done_cyc,    exp_done);
    chk({nm, ".done_count"}, done_pulses, (exp_done != 0) ? 1 : 0);
    chk({nm, ".valid_low"},  valid_low,   1'b1);
    chk({nm, ".busy_prof"},  busy_ok,     1'b1);
    chk({nm, ".valid_end"},  kernel_valid, exp_done != 0);
    chk({nm, ".bus"},        kernel_bus,  (exp_done != 0) ? exp_bus : '0);
    if (start_clr) chk({nm, ".bus_zeroed"}, early_zero, 1'b1);
`ifdef WLOAD_CHECKSUM_EN
    chk({nm, ".sum"}, kernel_sum, (exp_done != 0) ? (W+AW)'(exp_sum) : '0);
`endif
  endtask

  typedef struct {
    string nm;
    int    img;
    int    clr_at;
    int    restart_at;
    bit    start_clr;
    int    exp_done;
    int    exp_reads;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"T1_inc",        0, 0,  0,  1'b0, KS+2, KS};
    vecs[1] = '{"T2_allFF",      1, 0,  0,  1'b0, KS+2, KS};
    vecs[2] = '{"T3_restart10",  2, 0,  10, 1'b0, KS+2, KS};
    vecs[3] = '{"T6_start_clr",  3, 0,  0,  1'b1, KS+2, KS};
    vecs[4] = '{"T4_clr12",      0, 12, 0,  1'b0, 0,    12};
    vecs[5] = '{"restart_drain", 3, 0,  26, 1'b0, KS+2, KS};

    rst = 1'b1; load_start = 1'b0; kernel_clr = 1'b0;
    set_image(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy",  busy,         1'b0);
    chk("rst.ren",   rom_r_en,     1'b0);
    chk("rst.raddr", rom_raddr,    '0);
    chk("rst.done",  load_done,    1'b0);
    chk("rst.valid", kernel_valid, 1'b0);
    chk("rst.bus",   kernel_bus,   '0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_image(vecs[i].img);
      run_load(vecs[i].nm, vecs[i].clr_at, vecs[i].restart_at, vecs[i].start_clr,
               vecs[i].exp_done, vecs[i].exp_reads);
    end

    // Asynchronous reset in the middle of a read burst.
    set_image(2);
    run_load("pre_rst", 0, 0, 1'b0, KS+2, KS);
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("T5.busy",  busy,         1'b0);
    chk("T5.ren",   rom_r_en,     1'b0);
    chk("T5.raddr", rom_raddr,    '0);
    chk("T5.done",  load_done,    1'b0);
    chk("T5.valid", kernel_valid, 1'b0);
    chk("T5.bus",   kernel_bus,   '0);
`ifdef WLOAD_CHECKSUM_EN
    chk("T5.sum",   kernel_sum,   '0);
`endif
    #2 rst = 1'b0;
    set_image(3);
    run_load("T5_after", 0, 0, 1'b0, KS+2, KS);

    // Randomized loads against the arithmetic model above.
    for (int it = 0; it < 10; it++) begin
      int mode, c;
      set_image(2);
      mode = int'($urandom_range(0, 3));
      c    = int'($urandom_range(1, KS + 1));
      case (mode)
        0: run_load("rnd_plain",   0, 0, 1'b0, KS+2, KS);
        1: run_load("rnd_restart", 0, c, 1'b0, KS+2, KS);
        2: run_load("rnd_clr",     c, 0, 1'b0, 0, (c < KS) ? c : KS);
        default: run_load("rnd_startclr", 0, 0, 1'b1, KS+2, KS);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
